// File: rtl/alu_op_scheduler.sv
// Two-requester round-robin front end for a shared vector ALU: accepts one op, waits ALU_LAT, holds the result.
// Accept-to-rsp_valid is ALU_LAT+2 cycles; req_ready stays low until the held response is consumed.
module alu_op_scheduler #(
  parameter int WIDTH   = 4,
  parameter int n_alu   = 4,
  parameter int SEL_W   = 3,
  parameter int ALU_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [2*WIDTH*n_alu-1:0]   req_a,
  input  logic [2*WIDTH*n_alu-1:0]   req_b,
  input  logic [2*SEL_W-1:0]         req_sel,
  output logic [WIDTH*n_alu-1:0]     alu_a,
  output logic [WIDTH*n_alu-1:0]     alu_b,
  output logic [SEL_W-1:0]           alu_select,
  input  logic [WIDTH*n_alu-1:0]     alu_data_out,
  input  logic [n_alu-1:0]           alu_carry_out,
  input  logic [n_alu-1:0]           alu_a_greater,
  input  logic [n_alu-1:0]           alu_a_equal,
  input  logic [n_alu-1:0]           alu_a_less,
  output logic [1:0]                 rsp_valid,
  input  logic [1:0]                 rsp_ready,
  output logic [WIDTH*n_alu-1:0]     rsp_data,
  output logic [n_alu-1:0]           rsp_carry,
  output logic [3*n_alu-1:0]         rsp_flags,
  output logic                       busy,
  output logic                       grant_id
);

  localparam int V = WIDTH * n_alu;
  localparam logic [2:0] LAT = 3'(ALU_LAT);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t               state_q, state_d;
  logic                 last_q, last_d;
  logic                 gid_q, gid_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [V-1:0]         alu_a_q, alu_a_d;
  logic [V-1:0]         alu_b_q, alu_b_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [V-1:0]         data_q, data_d;
  logic [n_alu-1:0]     carry_q, carry_d;
  logic [3*n_alu-1:0]   flags_q, flags_d;
  logic                 gnt;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gid_d     = gid_q;
    cnt_d     = cnt_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    sel_d     = sel_q;
    data_d    = data_q;
    carry_d   = carry_q;
    flags_d   = flags_q;
    req_ready = 2'b00;
    // A tie goes to whoever did not complete last; a lone request wins outright.
    gnt       = (req_valid == 2'b11) ? ~last_q : req_valid[1];
    case (state_q)
      IDLE: begin
        if (|req_valid && !rst) begin
          req_ready = gnt ? 2'b10 : 2'b01;
          alu_a_d   = gnt ? req_a[V +: V] : req_a[0 +: V];
          alu_b_d   = gnt ? req_b[V +: V] : req_b[0 +: V];
          sel_d     = gnt ? req_sel[SEL_W +: SEL_W] : req_sel[0 +: SEL_W];
          gid_d     = gnt;
          cnt_d     = LAT;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 3'd0) begin
          data_d  = alu_data_out;
          carry_d = alu_carry_out;
          flags_d = {alu_a_greater, alu_a_equal, alu_a_less};
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready[gid_q]) begin
          last_d  = gid_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gid_q   <= 1'b0;
      cnt_q   <= 3'd0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      carry_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      flags_q <= flags_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_select = sel_q;
  assign rsp_data   = data_q;
  assign rsp_carry  = carry_q;
  assign rsp_flags  = flags_q;
  assign rsp_valid  = (state_q == RESP) ? (gid_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy       = (state_q != IDLE);
  assign grant_id   = gid_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Bench for alu_op_scheduler with a per-lane add-mod-16 ALU stand-in (WIDTH=4, n_alu=4, ALU_LAT=1).
module tb_alu_op_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_a, req_b;
  logic [5:0]  req_sel;
  logic [15:0] alu_a, alu_b, alu_data_out, rsp_data;
  logic [2:0]  alu_select;
  logic [3:0]  alu_carry_out, alu_a_greater, alu_a_equal, alu_a_less, rsp_carry;
  logic [11:0] rsp_flags;
  logic        busy, grant_id;

  int n_cmp = 0;
  int n_fail = 0;

  alu_op_scheduler dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
    .alu_data_out(alu_data_out), .alu_carry_out(alu_carry_out),
    .alu_a_greater(alu_a_greater), .alu_a_equal(alu_a_equal), .alu_a_less(alu_a_less),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_flags(rsp_flags),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // ALU stand-in: per-lane 4-bit add with carry and compare flags.
  always_comb begin
    logic [4:0] s;
    alu_data_out  = '0;
    alu_carry_out = '0;
    alu_a_greater = '0;
    alu_a_equal   = '0;
    alu_a_less    = '0;
    for (int k = 0; k < 4; k++) begin
      s = {1'b0, alu_a[k*4 +: 4]} + {1'b0, alu_b[k*4 +: 4]};
      alu_data_out[k*4 +: 4] = s[3:0];
      alu_carry_out[k]       = s[4];
      alu_a_greater[k]       = alu_a[k*4 +: 4] > alu_b[k*4 +: 4];
      alu_a_equal[k]         = alu_a[k*4 +: 4] == alu_b[k*4 +: 4];
      alu_a_less[k]          = alu_a[k*4 +: 4] < alu_b[k*4 +: 4];
    end
  end

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  c;
    logic [11:0] f;
  } res_t;

  typedef struct {
    int          req;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  sel;
    logic [15:0] exp_d;
    logic [3:0]  exp_c;
  } vec_t;

  // Reference: integer arithmetic per lane.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b);
    res_t r;
    int x, y, s;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      x = int'((a >> (4 * k)) & 16'hF);
      y = int'((b >> (4 * k)) & 16'hF);
      s = x + y;
      r.d = r.d | 16'((s % 16) << (4 * k));
      r.c[k]     = (s > 15);
      r.f[8 + k] = (x > y);
      r.f[4 + k] = (x == y);
      r.f[k]     = (x < y);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (rsp_valid == 2'b00 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic single_op(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] sel, input logic [15:0] ed, input logic [3:0] ec);
    int lat;
    logic [1:0] oh;
    oh = (i == 1) ? 2'b10 : 2'b01;
    tick();
    req_valid = oh;
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
    req_sel[i*3 +: 3] = sel;
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("op_req_ready", req_ready, oh);
    tick();
    req_valid = 2'b00;
    req_a = $urandom;
    req_b = $urandom;
    req_sel = 6'($urandom);
    @(negedge clk);
    chk("op_alu_a", alu_a, a);
    chk("op_alu_b", alu_b, b);
    chk("op_alu_select", alu_select, sel);
    chk("op_grant_id", grant_id, i);
    chk("op_busy", busy, 1);
    wait_rsp(lat);
    chk("op_latency", lat, 3);
    chk("op_rsp_valid", rsp_valid, oh);
    chk("op_rsp_data", rsp_data, ed);
    chk("op_rsp_carry", rsp_carry, ec);
    tick();
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("op_done_valid", rsp_valid, 0);
    chk("op_done_busy", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int lat, ng, cyc, last_acc;
    logic have, last_g, exp_id, hs;
    int age, ncomp;
    logic [1:0] exp_rdy, exp_vld;
    logic [15:0] exp_a, exp_b;
    logic [2:0] exp_sel;
    res_t exp_res;

    vecs[0] = '{0, 16'h1234, 16'h1111, 3'd0, 16'h2345, 4'b0000};
    vecs[1] = '{1, 16'hFFFF, 16'h0001, 3'd5, 16'hFFF0, 4'b0001};
    vecs[2] = '{0, 16'h8888, 16'h8888, 3'd7, 16'h0000, 4'b1111};
    vecs[3] = '{1, 16'h0F0F, 16'h0101, 3'd2, 16'h0000, 4'b0101};
    vecs[4] = '{0, 16'h1234, 16'h4321, 3'd3, 16'h5555, 4'b0000};
    vecs[5] = '{1, 16'hF0F0, 16'h1F1F, 3'd1, 16'h0F0F, 4'b1010};

    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_a = '0;
    req_b = '0;
    req_sel = '0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_select", alu_select, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_carry", rsp_carry, 0);
    chk("rst_rsp_flags", rsp_flags, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);

    // Both requesters valid straight out of reset: 0,1,0,1 every 4 cycles.
    tick();
    rst = 1'b0;
    req_a = {16'hAAAA, 16'h1234};
    req_b = {16'h1111, 16'h1111};
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    ng = 0;
    cyc = 0;
    last_acc = 0;
    while (ng < 4 && cyc < 100) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        chk("tie_grant", req_ready, (ng % 2 == 1) ? 2'b10 : 2'b01);
        if (ng > 0) chk("tie_gap", cyc - last_acc, 4);
        last_acc = cyc;
        ng++;
      end
      cyc++;
    end
    chk("tie_count", ng, 4);
    tick();
    req_valid = 2'b00;
    repeat (6) tick();
    rsp_ready = 2'b00;

    foreach (vecs[n])
      single_op(vecs[n].req, vecs[n].a, vecs[n].b, vecs[n].sel, vecs[n].exp_d, vecs[n].exp_c);

    // Held response with a competing request pending.
    tick();
    req_valid = 2'b01;
    req_a[15:0] = 16'h1357;
    req_b[15:0] = 16'h2468;
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("bp_accept", req_ready, 2'b01);
    tick();
    req_valid = 2'b10;
    req_a[31:16] = 16'h0001;
    req_b[31:16] = 16'h0001;
    @(negedge clk);
    wait_rsp(lat);
    chk("bp_latency", lat, 3);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", rsp_valid, 2'b01);
      chk("bp_hold_data", rsp_data, 16'h37BF);
      chk("bp_hold_ready", req_ready, 2'b00);
      tick();
      if (k == 4) rsp_ready = 2'b01;
      @(negedge clk);
    end
    chk("bp_last_valid", rsp_valid, 2'b01);
    tick();
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("bp_single_completion", rsp_valid, 2'b00);
    chk("bp_next_grant", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    rsp_ready = 2'b10;
    repeat (5) tick();
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("bp_drained_busy", busy, 0);
    chk("bp_drained_valid", rsp_valid, 0);

    // Reset while in EXEC.
    tick();
    req_valid = 2'b10;
    req_a[31:16] = 16'h5555;
    req_b[31:16] = 16'h1111;
    @(negedge clk);
    chk("rm_accept", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    chk("rm_in_exec", busy, 1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rm_rsp_valid", rsp_valid, 0);
    chk("rm_busy", busy, 0);
    chk("rm_alu_a", alu_a, 0);
    chk("rm_grant_id", grant_id, 0);
    tick();
    req_valid = 2'b11;
    req_a = {16'h7777, 16'h0123};
    req_b = {16'h7777, 16'h0111};
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("rm_first_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    wait_rsp(lat);
    chk("rm_latency", lat, 3);
    chk("rm_rsp_valid_after", rsp_valid, 2'b01);
    chk("rm_rsp_data", rsp_data, 16'h0234);
    repeat (3) tick();
    rsp_ready = 2'b00;

    // Randomized traffic against a transaction-level scoreboard.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    have = 1'b0;
    last_g = 1'b1;
    exp_id = 1'b0;
    age = 0;
    ncomp = 0;
    exp_a = '0;
    exp_b = '0;
    exp_sel = '0;
    exp_res = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (have) age++;
      if (have || req_valid == 2'b00) exp_rdy = 2'b00;
      else if (req_valid == 2'b11) exp_rdy = last_g ? 2'b01 : 2'b10;
      else exp_rdy = req_valid;
      exp_vld = (have && age >= 3) ? (exp_id ? 2'b10 : 2'b01) : 2'b00;
      chk("rnd_req_ready", req_ready, exp_rdy);
      chk("rnd_rsp_valid", rsp_valid, exp_vld);
      if (have && age == 1) begin
        chk("rnd_alu_a", alu_a, exp_a);
        chk("rnd_alu_b", alu_b, exp_b);
        chk("rnd_alu_select", alu_select, exp_sel);
        chk("rnd_grant_id", grant_id, exp_id);
      end
      if (exp_vld != 2'b00) begin
        chk("rnd_rsp_data", rsp_data, exp_res.d);
        chk("rnd_rsp_carry", rsp_carry, exp_res.c);
        chk("rnd_rsp_flags", rsp_flags, exp_res.f);
      end
      hs = (exp_vld != 2'b00) && rsp_ready[exp_id];
      tick();
      if (hs) begin
        have = 1'b0;
        last_g = exp_id;
        ncomp++;
      end
      if (exp_rdy != 2'b00) begin
        have = 1'b1;
        age = 0;
        exp_id = exp_rdy[1];
        exp_a = req_a[exp_id*16 +: 16];
        exp_b = req_b[exp_id*16 +: 16];
        exp_sel = req_sel[exp_id*3 +: 3];
        exp_res = model(exp_a, exp_b);
      end
      for (int i = 0; i < 2; i++) begin
        if (exp_rdy[i] || (!req_valid[i] && $urandom_range(0, 2) == 0)) begin
          req_valid[i] = exp_rdy[i] ? 1'($urandom_range(0, 1)) : 1'b1;
          req_a[i*16 +: 16] = 16'($urandom);
          req_b[i*16 +: 16] = 16'($urandom);
          req_sel[i*3 +: 3] = 3'($urandom);
        end else if (req_valid[i] && $urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = 2'($urandom_range(0, 3));
    end
    chk("rnd_enough_completions", (ncomp > 100) ? 1 : 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_scheduler.md
ALU_OP_SCHEDULER -- requirements
Module: alu_op_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the lane width in bits.
REQ-002 SHALL have parameter n_alu, default 4, the number of ALU lanes; V = WIDTH*n_alu.
REQ-003 SHALL have parameter SEL_W, default 3, the select width.
REQ-004 SHALL have parameter ALU_LAT, default 1 (range 1..7), the cycles from alu_a/alu_b/alu_select stable to alu_* results valid.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port req_valid, input, 2 bits: requester i has an operation pending.
REQ-008 SHALL have port req_ready, output, 2 bits: requester i's operation is accepted this cycle.
REQ-009 SHALL have ports req_a and req_b, input, 2*V bits each: requester i's operands at slice [i*V +: V].
REQ-010 SHALL have port req_sel, input, 2*SEL_W bits: requester i's select at slice [i*SEL_W +: SEL_W].
REQ-011 SHALL have ports alu_a and alu_b (V bits each) and alu_select (SEL_W bits), all outputs: registered operands driven to the vector ALU.
REQ-012 SHALL have port alu_data_out, input, V bits: the ALU result.
REQ-013 SHALL have port alu_carry_out, input, n_alu bits: the ALU per-lane carry.
REQ-014 SHALL have ports alu_a_greater, alu_a_equal and alu_a_less, inputs, n_alu bits each: the ALU per-lane compare flags.
REQ-015 SHALL have port rsp_valid, output, 2 bits: a response is held for requester i.
REQ-016 SHALL have port rsp_ready, input, 2 bits: requester i consumes its response.
REQ-017 SHALL have ports rsp_data (V bits), rsp_carry (n_alu bits) and rsp_flags (3*n_alu bits, {greater,equal,less}), all outputs: the captured result.
REQ-018 SHALL have ports busy (1 bit) and grant_id (1 bit), outputs: busy = state != IDLE; grant_id = the requester currently owning the ALU.

Function
REQ-019 SHALL implement FSM states IDLE, EXEC and RESP.
REQ-020 In IDLE, SHALL select a grant combinationally: only one req_valid high -> that requester; both high -> requester != last_grant (round-robin).
REQ-021 req_ready[g] SHALL be 1 only in IDLE, only for the granted g, and at most one bit per cycle; the req_valid -> req_ready path is combinational.
REQ-022 On acceptance, SHALL register requester g's slices into alu_a/alu_b/alu_select, set grant_id=g and cnt=ALU_LAT, and go to EXEC.
REQ-023 In EXEC, SHALL decrement cnt each cycle; in the cycle cnt==0 it SHALL capture alu_data_out, alu_carry_out and the flags into the rsp_* registers and go to RESP.
REQ-024 In RESP, SHALL hold rsp_valid[grant_id]=1 with rsp_* stable until rsp_ready[grant_id]=1; then last_grant <= grant_id and the next state is IDLE.
REQ-025 rsp_ready on the non-granted bit SHALL be ignored; rsp_valid SHALL never have both bits set.
REQ-026 Latency from the accept cycle to first rsp_valid SHALL be exactly ALU_LAT+2 cycles; back-to-back throughput SHALL be one operation per ALU_LAT+3 cycles with immediate rsp_ready.
REQ-027 alu_* outputs SHALL hold their last values outside the accept edge; the block SHALL perform no arithmetic and pass the result through unmodified.
REQ-028 req_valid dropped before acceptance SHALL cancel that request with no side effects; changes to req_* during EXEC/RESP SHALL be ignored.

Reset
REQ-029 rst SHALL set the state to IDLE, last_grant to 1 (so requester 0 wins the first tie), and all outputs to 0: alu_a, alu_b, alu_select, rsp_*, rsp_valid, grant_id, busy.
REQ-030 rst asserted in EXEC or RESP SHALL discard the in-flight operation; rsp_valid SHALL be 0 in the cycle after the reset edge.
REQ-031 rst SHALL take priority over acceptance and response handshakes in the same cycle.

Verification
(Bench ALU stub: ALU_LAT=1, per-lane add mod 16; WIDTH=4, n_alu=4.)
REQ-032 Single op: req0 a=16'h1234, b=16'h1111, sel=3'd0 -> req_ready=2'b01 once; alu_a=16'h1234 next cycle; rsp_valid=2'b01 three cycles after accept with rsp_data=16'h2345.
REQ-033 Tie: both requesters valid from reset -> requester 0 is granted first, then requester 1; with both held valid, grants alternate 0,1,0,1 over four ops.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data are stable for all 5 cycles; req_ready=0 throughout; exactly one completion when rsp_ready rises.
REQ-035 Lane carry: a=16'hFFFF, b=16'h0001 -> rsp_data=16'hFFF0, and rsp_carry equals alu_carry_out as captured.
REQ-036 Reset mid-op: rst asserted in EXEC -> rsp_valid=0, busy=0 and alu_a=0 after the reset edge; the next request is served normally starting from requester 0.
